// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Contents:
//   pc_state_e  sequencer states (RUN / MC_WAIT)
//   ZeroReg     address of x0, which is never a real data dependency
//   RegAddrBus  register-file address type
//   INST_NOP    encoding loaded into flushed pipeline registers
package pipe_ctrl_pkg;

  typedef enum logic {
    PC_ST_RUN    = 1'b0,
    PC_ST_MCWAIT = 1'b1
  } pc_state_e;

  typedef logic [4:0] RegAddrBus;

  localparam RegAddrBus   ZeroReg  = '0;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
//   master : datapath side, drives hazard sources, receives lden/flush/sel
//   slave  : pipe_ctrl side
// Hazard sources : id_rs1/rs2 addr+ren, ex_rd_addr, ex_regs_wen, ex_is_load,
//                  ex_jump_req, ex_mc_start, ex_mc_done, mem_stall_req
// Controls       : pc_lden, pc_sel_jump, if_id_lden/flush, id_ex_lden/flush,
//                  ex_mem_lden, ex_mem_bubble
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  RegAddrBus id_rs1_addr;
  RegAddrBus id_rs2_addr;
  logic      id_rs1_ren;
  logic      id_rs2_ren;
  RegAddrBus ex_rd_addr;
  logic      ex_regs_wen;
  logic      ex_is_load;
  logic      ex_jump_req;
  logic      ex_mc_start;
  logic      ex_mc_done;
  logic      mem_stall_req;

  logic      pc_lden;
  logic      pc_sel_jump;
  logic      if_id_lden;
  logic      if_id_flush;
  logic      id_ex_lden;
  logic      id_ex_flush;
  logic      ex_mem_lden;
  logic      ex_mem_bubble;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
           ex_rd_addr, ex_regs_wen, ex_is_load, ex_jump_req,
           ex_mc_start, ex_mc_done, mem_stall_req,
    input  pc_lden, pc_sel_jump, if_id_lden, if_id_flush,
           id_ex_lden, id_ex_flush, ex_mem_lden, ex_mem_bubble
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_ren, id_rs2_ren,
           ex_rd_addr, ex_regs_wen, ex_is_load, ex_jump_req,
           ex_mc_start, ex_mc_done, mem_stall_req,
    output pc_lden, pc_sel_jump, if_id_lden, if_id_flush,
           id_ex_lden, id_ex_flush, ex_mem_lden, ex_mem_bubble
  );

endinterface

// File: rtl/gnrl_dfflr.sv
// General-purpose load-enable flop with synchronous active-high reset.
//   clk  : clock
//   rst  : synchronous reset, 1 = clear to zero
//   lden : load enable
//   dnxt : next value
//   qout : registered value
module gnrl_dfflr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (lden) begin
      q_q <= dnxt;
    end
  end

  assign qout = q_q;

endmodule

// File: rtl/hazard_det.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// is read by the instruction in ID. Purely combinational so the forwarding
// unit can reuse it.
//   ex_is_load_i, ex_regs_wen_i, ex_rd_addr_i : producer in EX
//   id_rs{1,2}_addr_i, id_rs{1,2}_ren_i       : consumer in ID
//   load_use_o                                : hazard present
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic      ex_is_load_i,
  input  logic      ex_regs_wen_i,
  input  RegAddrBus ex_rd_addr_i,
  input  RegAddrBus id_rs1_addr_i,
  input  RegAddrBus id_rs2_addr_i,
  input  logic      id_rs1_ren_i,
  input  logic      id_rs2_ren_i,
  output logic      load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit    = id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i);
    // x0 writes are discarded, so they never create a dependency.
    load_use_o = ex_is_load_i & ex_regs_wen_i & (ex_rd_addr_i != ZeroReg)
               & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage pipeline.
// Priority: bus stall > multicycle EX op > EX redirect > load-use.
//   clk        : clock
//   rstn       : synchronous reset, active-high despite the name
//   pb         : pipe_ctrl_if.slave, hazard sources in, lden/flush/sel out
//   mc_timeout : sticky, multicycle watchdog fired (cleared by reset only)
//   stall_cnt  : saturating count of cycles with pc_lden=0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  pipe_ctrl_if.slave       pb,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MC_CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

  pc_state_e           state_q, state_d;
  logic [0:0]          state_raw;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                timeout_set;
  logic                load_use;
  logic                mc_start_now;
  logic                mc_hold;
  logic                stall_cnt_ld;

  hazard_det u_hazard_det (
    .ex_is_load_i  (pb.ex_is_load),
    .ex_regs_wen_i (pb.ex_regs_wen),
    .ex_rd_addr_i  (pb.ex_rd_addr),
    .id_rs1_addr_i (pb.id_rs1_addr),
    .id_rs2_addr_i (pb.id_rs2_addr),
    .id_rs1_ren_i  (pb.id_rs1_ren),
    .id_rs2_ren_i  (pb.id_rs2_ren),
    .load_use_o    (load_use)
  );

  // State register
  gnrl_dfflr #(.DW(1)) u_state_dff (
    .clk  (clk),
    .rst  (rstn),
    .lden (1'b1),
    .dnxt (state_d),
    .qout (state_raw)
  );
  assign state_q = pc_state_e'(state_raw);

  gnrl_dfflr #(.DW(MC_CNT_W)) u_mc_cnt_dff (
    .clk  (clk),
    .rst  (rstn),
    .lden (1'b1),
    .dnxt (mc_cnt_d),
    .qout (mc_cnt_q)
  );

  gnrl_dfflr #(.DW(1)) u_mc_timeout_dff (
    .clk  (clk),
    .rst  (rstn),
    .lden (timeout_set),
    .dnxt (1'b1),
    .qout (mc_timeout)
  );

  assign stall_cnt_ld = ~pb.pc_lden & ~(&stall_cnt);

  gnrl_dfflr #(.DW(CNT_W)) u_stall_cnt_dff (
    .clk  (clk),
    .rst  (rstn),
    .lden (stall_cnt_ld),
    .dnxt (stall_cnt + 1'b1),
    .qout (stall_cnt)
  );

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    timeout_set = 1'b0;
    unique case (state_q)
      PC_ST_RUN: begin
        if (pb.ex_mc_start & ~pb.ex_mc_done & ~pb.mem_stall_req) begin
          state_d  = PC_ST_MCWAIT;
          mc_cnt_d = '0;
        end
      end
      PC_ST_MCWAIT: begin
        // mc_cnt keeps running through bus stalls; done beats the watchdog.
        if (pb.ex_mc_done) begin
          state_d = PC_ST_RUN;
        end else if (mc_cnt_q == MC_LAST) begin
          state_d     = PC_ST_RUN;
          timeout_set = 1'b1;
        end else begin
          mc_cnt_d = mc_cnt_q + 1'b1;
        end
      end
      default: state_d = PC_ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    // The start cycle already holds the front end while EX owns the op.
    mc_start_now = (state_q == PC_ST_RUN) & pb.ex_mc_start & ~pb.ex_mc_done;
    mc_hold      = (state_q == PC_ST_MCWAIT) | mc_start_now;

    pb.pc_lden       = 1'b0;
    pb.pc_sel_jump   = 1'b0;
    pb.if_id_lden    = 1'b0;
    pb.if_id_flush   = 1'b0;
    pb.id_ex_lden    = 1'b0;
    pb.id_ex_flush   = 1'b0;
    pb.ex_mem_lden   = 1'b0;
    pb.ex_mem_bubble = 1'b0;

    if (!rstn) begin
      if (pb.mem_stall_req) begin
        // Full freeze; the held EX instruction re-presents its requests.
      end else if (mc_hold) begin
        pb.ex_mem_lden   = 1'b1;
        pb.ex_mem_bubble = 1'b1;
      end else if (pb.ex_jump_req) begin
        pb.pc_lden     = 1'b1;
        pb.pc_sel_jump = 1'b1;
        pb.if_id_lden  = 1'b1;
        pb.if_id_flush = 1'b1;
        pb.id_ex_lden  = 1'b1;
        pb.id_ex_flush = 1'b1;
        pb.ex_mem_lden = 1'b1;
      end else if (load_use) begin
        pb.id_ex_lden  = 1'b1;
        pb.id_ex_flush = 1'b1;
        pb.ex_mem_lden = 1'b1;
      end else begin
        pb.pc_lden     = 1'b1;
        pb.if_id_lden  = 1'b1;
        pb.id_ex_lden  = 1'b1;
        pb.ex_mem_lden = 1'b1;
      end
    end
  end

endmodule
